// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue: compacts masked fetch packets
// into a circular buffer and presents the oldest group to decode.
package riscv;
  localparam int FRONTEND_WIDTH = 2;
  localparam int XLEN = 32;
endpackage

module fetch_buffer #(
  parameter int FRONTEND_WIDTH = riscv::FRONTEND_WIDTH,
  parameter int XLEN = riscv::XLEN,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush_i,
  input  logic fetch_valid_i,
  input  logic [FRONTEND_WIDTH-1:0] fetch_mask_i,
  input  logic [FRONTEND_WIDTH-1:0][XLEN-1:0] fetch_instr_i,
  input  logic [FRONTEND_WIDTH-1:0][XLEN-1:0] fetch_pc_i,
  output logic fetch_ready_o,
  output logic [FRONTEND_WIDTH-1:0] dec_valid_o,
  output logic [FRONTEND_WIDTH-1:0][XLEN-1:0] dec_instr_o,
  output logic [FRONTEND_WIDTH-1:0][XLEN-1:0] dec_pc_o,
  input  logic dec_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] instr_d [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];

  logic push, pop;
  cnt_t n_push, n_pop;
  ptr_t off [FRONTEND_WIDTH];

  assign fetch_ready_o = count_q <= cnt_t'(DEPTH - FRONTEND_WIDTH);
  assign push = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign pop  = dec_ready_i & ~flush_i;

  // off[j]: write offset of slot j after squeezing out mask holes
  always_comb begin
    n_push = '0;
    for (int j = 0; j < FRONTEND_WIDTH; j++) begin
      off[j] = n_push[PW-1:0];
      if (fetch_mask_i[j]) n_push = n_push + cnt_t'(1);
    end
  end

  assign n_pop = (count_q > cnt_t'(FRONTEND_WIDTH))
               ? cnt_t'(FRONTEND_WIDTH) : count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        for (int j = 0; j < FRONTEND_WIDTH; j++) begin
          if (fetch_mask_i[j]) begin
            instr_d[tail_q + off[j]] = fetch_instr_i[j];
            pc_d[tail_q + off[j]]    = fetch_pc_i[j];
          end
        end
        tail_d = tail_q + n_push[PW-1:0];
      end
      if (pop) head_d = head_q + n_pop[PW-1:0];
      count_d = count_q + (push ? n_push : '0)
                        - (pop ? n_pop : '0);
    end
  end

  always_comb begin
    ptr_t idx;
    idx = '0;
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
      idx = head_q + ptr_t'(i);
      dec_valid_o[i] = count_q > cnt_t'(i);
      dec_instr_o[i] = dec_valid_o[i] ? instr_q[idx] : '0;
      dec_pc_o[i]    = dec_valid_o[i] ? pc_q[idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer; a queue scoreboard holds the
// expected buffer contents and a negedge monitor checks the outputs.
module tb_fetch_buffer;

  localparam int FW = 2;
  localparam int XL = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush_i = 1'b0;
  logic fetch_valid_i = 1'b0;
  logic [FW-1:0] fetch_mask_i = '0;
  logic [FW-1:0][XL-1:0] fetch_instr_i = '0;
  logic [FW-1:0][XL-1:0] fetch_pc_i = '0;
  logic fetch_ready_o;
  logic [FW-1:0] dec_valid_o;
  logic [FW-1:0][XL-1:0] dec_instr_o;
  logic [FW-1:0][XL-1:0] dec_pc_o;
  logic dec_ready_i = 1'b0;

  fetch_buffer #(.FRONTEND_WIDTH(FW), .XLEN(XL), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .resetn(resetn),
    .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_mask_i(fetch_mask_i),
    .fetch_instr_i(fetch_instr_i),
    .fetch_pc_i(fetch_pc_i),
    .fetch_ready_o(fetch_ready_o),
    .dec_valid_o(dec_valid_o),
    .dec_instr_o(dec_instr_o),
    .dec_pc_o(dec_pc_o),
    .dec_ready_i(dec_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XL-1:0] pc;
    logic [XL-1:0] instr;
  } ent_t;

  ent_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  function automatic logic [XL-1:0] instr_of(input logic [XL-1:0] pc);
    return pc ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [XL-1:0] act,
                     input logic [XL-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare outputs to the scoreboard, then retire/accept
  // entries according to the inputs that will be sampled next edge.
  always @(negedge clk) begin
    int sz;
    bit rdy;
    ent_t e;
    if (!done) begin
      if (!resetn) exp_q.delete();
      sz = exp_q.size();
      rdy = (sz <= DEPTH - FW);
      chk("ready", 32'(fetch_ready_o), 32'(rdy));
      chk("count", 32'(dut.count_q), 32'(sz));
      for (int i = 0; i < FW; i++) begin
        chk($sformatf("valid%0d", i), 32'(dec_valid_o[i]), 32'(sz > i));
        chk($sformatf("pc%0d", i), dec_pc_o[i],
            (sz > i) ? exp_q[i].pc : '0);
        chk($sformatf("instr%0d", i), dec_instr_o[i],
            (sz > i) ? exp_q[i].instr : '0);
      end
      if (resetn) begin
        if (flush_i) begin
          exp_q.delete();
        end else begin
          if (dec_ready_i)
            for (int i = 0; i < FW && i < sz; i++) void'(exp_q.pop_front());
          if (fetch_valid_i && rdy)
            for (int j = 0; j < FW; j++)
              if (fetch_mask_i[j]) begin
                e.pc = fetch_pc_i[j];
                e.instr = fetch_instr_i[j];
                exp_q.push_back(e);
              end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [FW-1:0] m,
                       input logic [XL-1:0] p0, input logic [XL-1:0] p1,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #2;
    fetch_valid_i = v;
    fetch_mask_i = m;
    fetch_pc_i[0] = p0;
    fetch_pc_i[1] = p1;
    fetch_instr_i[0] = instr_of(p0);
    fetch_instr_i[1] = instr_of(p1);
    dec_ready_i = rdy;
    flush_i = fl;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 2'b00, '0, '0, rdy, 1'b0);
  endtask

  logic [XL-1:0] pc;

  initial begin
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    // full packet, no decode
    drive(1, 2'b11, 32'h0, 32'h4, 0, 0);
    idle(0);
    idle(1);
    // compaction across holes
    drive(1, 2'b10, 32'h10, 32'h14, 0, 0);
    drive(1, 2'b01, 32'h18, 32'h1c, 0, 0);
    idle(0);
    idle(1);
    idle(1);
    // fill to 7, hold a packet while full
    drive(1, 2'b11, 32'h20, 32'h24, 0, 0);
    drive(1, 2'b11, 32'h28, 32'h2c, 0, 0);
    drive(1, 2'b11, 32'h30, 32'h34, 0, 0);
    drive(1, 2'b01, 32'h38, 32'h3c, 0, 0);
    repeat (3) drive(1, 2'b11, 32'h40, 32'h44, 0, 0);
    drive(1, 2'b11, 32'h40, 32'h44, 1, 0);
    drive(1, 2'b11, 32'h40, 32'h44, 0, 0);
    idle(1);
    idle(1);
    // count 3: sustained push+pop with wrap
    pc = 32'h48;
    for (int k = 0; k < 20; k++) begin
      drive(1, 2'b11, pc, pc + 4, 1, 0);
      pc += 8;
    end
    // drain through a count of 1
    idle(1);
    idle(1);
    idle(1);
    idle(1);
    // count 5 then flush with a colliding push
    drive(1, 2'b11, 32'h200, 32'h204, 0, 0);
    drive(1, 2'b11, 32'h208, 32'h20c, 0, 0);
    drive(1, 2'b01, 32'h210, 32'h214, 0, 0);
    drive(1, 2'b11, 32'h300, 32'h304, 1, 1);
    idle(0);
    drive(1, 2'b11, 32'h400, 32'h404, 0, 0);
    idle(0);
    // asynchronous reset mid-operation
    drive(1, 2'b11, 32'h408, 32'h40c, 0, 0);
    @(posedge clk);
    #3 resetn = 1'b0;
    fetch_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    drive(1, 2'b10, 32'h500, 32'h504, 0, 0);
    idle(1);
    idle(0);
    @(negedge clk);
    #1 done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction queue between the fetch unit and the `dec` stage. Accepts fetch packets of up to FRONTEND_WIDTH instructions per cycle, with a per-slot valid mask, and compacts them into an in-order circular buffer. Each cycle it presents the oldest up to FRONTEND_WIDTH instructions to the decoders. It absorbs fetch/decode rate mismatch and discards all contents on a pipeline flush.

## Interface
Parameters:
- FRONTEND_WIDTH, from `riscv` package (2): slots per fetch packet and per decode group.
- XLEN, from `riscv` package (32): instruction and PC width.
- DEPTH, 8: buffer entries. Must be a power of two and at least 2*FRONTEND_WIDTH.

Ports:
- clk  input  1  clock; single clock domain.
- resetn  input  1  asynchronous, active-low reset.
- flush_i  input  1  discard all buffered and incoming instructions.
- fetch_valid_i  input  1  a fetch packet is offered.
- fetch_mask_i  input  FRONTEND_WIDTH  per-slot valid; any pattern, including holes.
- fetch_instr_i  input  FRONTEND_WIDTH x XLEN  packet instructions.
- fetch_pc_i  input  FRONTEND_WIDTH x XLEN  packet PCs.
- fetch_ready_o  output  1  buffer can accept a full packet this cycle.
- dec_valid_o  output  FRONTEND_WIDTH  slot i holds the i-th oldest instruction.
- dec_instr_o  output  FRONTEND_WIDTH x XLEN  instructions to decode (feeds `dec.instr_i`).
- dec_pc_o  output  FRONTEND_WIDTH x XLEN  PCs (feeds `dec.pc_i`).
- dec_ready_i  input  1  decode consumes every slot flagged in dec_valid_o this cycle.

## Operation
State:
- Storage array of DEPTH entries, each {instr, pc}. Not reset.
- head_q and tail_q pointers, each log2(DEPTH) bits. They wrap modulo DEPTH naturally.
- count_q, log2(DEPTH)+1 bits, range 0..DEPTH.

Push:
- Push fires when fetch_valid_i & fetch_ready_o & !flush_i.
- Set slots of fetch_mask_i are written, compacted in ascending slot order, to tail_q, tail_q+1, and so on.
- n_push = popcount(fetch_mask_i).
- A zero mask is a legal no-op handshake.

Ready:
- fetch_ready_o = (DEPTH - count_q) >= FRONTEND_WIDTH.
- It depends only on registered count_q, never on the mask or on a same-cycle pop.

Decode side:
- dec_valid_o[i] = (count_q > i).
- dec_instr_o[i] and dec_pc_o[i] come from entry head_q+i (mod DEPTH) when dec_valid_o[i] is set, and are 0 otherwise.
- Valid bits are always thermometer-coded from slot 0.

Pop:
- Pop fires when dec_ready_i & !flush_i.
- n_pop = min(count_q, FRONTEND_WIDTH).
- Partial groups are consumed: the buffer never waits to fill a full group.

Update on a non-flush cycle:
- head_q += n_pop.
- tail_q += n_push.
- count_q += n_push - n_pop.
- A simultaneous push and pop is legal at any count, including full and empty.

Flush:
- Next cycle: head_q = tail_q = count_q = 0.
- Any same-cycle push or pop is ignored.
- Flush has priority over every other event.

Invariants:
- count_q never exceeds DEPTH.
- count_q never underflows.
- Order out of the buffer equals order in: slot order within a packet, then packet order.

## Timing
- Reset values: count_q = 0, head_q = 0, tail_q = 0, fetch_ready_o = 1, dec_valid_o = 0, dec_instr_o = 0, dec_pc_o = 0.
- All outputs are combinational from registered state only. There is no combinational path from any input to any output.
- Latency: an instruction pushed in cycle N is visible on dec_* in cycle N+1, at the earliest.
- Full throughput: FRONTEND_WIDTH pushed and FRONTEND_WIDTH popped per cycle, sustained.
- Full: fetch_ready_o = 0 whenever count_q > DEPTH - FRONTEND_WIDTH. A fetch_valid_i offered then is not accepted; fetch must hold the packet.
- Empty: dec_valid_o = 0. dec_ready_i has no effect.
- Flush: dec_valid_o = 0 and fetch_ready_o = 1 in the cycle after flush_i.
- resetn low mid-operation clears all state immediately and asynchronously. Outputs take their reset values while resetn is low.

## Test plan
- Reset, then push mask 2'b11 with PCs 0x0/0x4 while dec_ready_i = 0. Next cycle: dec_valid_o = 2'b11, dec_pc_o = {0x4, 0x0}, count_q = 2.
- Push mask 2'b10 (PC 0x14 in slot 1), then mask 2'b01 (PC 0x18). Required: dec_pc_o[0] = 0x14, dec_pc_o[1] = 0x18, dec_valid_o = 2'b11, proving compaction.
- Fill to 7 entries with dec_ready_i = 0. Required: fetch_ready_o = 0 and no write while fetch_valid_i is held. Then pop one group; next cycle fetch_ready_o = 1 and count_q = 5.
- Sustained push 2'b11 plus dec_ready_i = 1 for 20 cycles from count_q = 3. Required: count_q stays 3, pointers wrap past 7, PC order is strictly sequential.
- count_q = 1 with dec_ready_i = 1. Required: dec_valid_o = 2'b01 and count_q = 0 next cycle.
- flush_i together with push 2'b11 and dec_ready_i at count_q = 5. Required next cycle: count_q = 0, dec_valid_o = 0, fetch_ready_o = 1, and the pushed packet is absent.
